// File: rtl/n2_icd_access_ctl.sv
// ---------------------------------------------------------------------------
// n2_icd_access_ctl
// Sequencing and arbitration controller for the icache data array.
// Three requesters share the array: fetch reads, CMU line fills and
// ASI/MBIST word accesses. One requester is granted per cycle with a
// combinational ack. Its controls are registered onto the bf-stage outputs
// for exactly one cycle. ASI read data returning on icd bus 0 is captured
// and presented with a one-cycle valid pulse.
//
// Ports
//   l2clk, arst                    clock, asynchronous active-high reset
//   fetch_req/index/word_en/quad_en, fetch_ack   fetch read request/grant
//   fill_req/index/way, fill_ack   line fill request/grant
//   asi_req/wr/index/way/word, asi_ack          ASI/MBIST request/grant
//   icd_rd_data                    array bus 0 instruction (c-stage)
//   tcu_array_wr_inhibit           blocks every write grant while high
//   asi_rd_data, asi_rd_vld        captured ASI read data and valid pulse
//   ic_rd_req_bf, ic_wr_req_bf, asi_mbist_access_bf,
//   index_bf, wrway_bf, word_en_bf, quad_en_bf  array bf-stage controls
// ---------------------------------------------------------------------------
module n2_icd_access_ctl #(
  parameter int STARVE_MAX = 4,
  parameter int RD_LAT     = 2
) (
  input  logic        l2clk,
  input  logic        arst,
  input  logic        fetch_req,
  input  logic [8:0]  fetch_index,
  input  logic [7:0]  fetch_word_en,
  input  logic [3:0]  fetch_quad_en,
  output logic        fetch_ack,
  input  logic        fill_req,
  input  logic [8:0]  fill_index,
  input  logic [2:0]  fill_way,
  output logic        fill_ack,
  input  logic        asi_req,
  input  logic        asi_wr,
  input  logic [8:0]  asi_index,
  input  logic [2:0]  asi_way,
  input  logic [2:0]  asi_word,
  output logic        asi_ack,
  input  logic [32:0] icd_rd_data,
  input  logic        tcu_array_wr_inhibit,
  output logic [32:0] asi_rd_data,
  output logic        asi_rd_vld,
  output logic        ic_rd_req_bf,
  output logic        ic_wr_req_bf,
  output logic        asi_mbist_access_bf,
  output logic [8:0]  index_bf,
  output logic [2:0]  wrway_bf,
  output logic [7:0]  word_en_bf,
  output logic [3:0]  quad_en_bf
);

  typedef enum logic [1:0] {IDLE, WR, WR_RCV} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  function automatic logic [7:0] word_onehot(input logic [2:0] sel);
    word_onehot = 8'b1 << sel;
  endfunction

  function automatic logic [3:0] quad_onehot(input logic [1:0] sel);
    quad_onehot = 4'b1 << sel;
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt;
  logic        asi_out;
  logic [RD_LAT-1:0] rd_sr;
  logic [RD_LAT:0]   rd_chain;
  logic        asi_rd_bf;

  logic        rd_ok, asi_elig, fill_elig, fetch_elig, starved;
  logic        wr_gnt, any_gnt, way_gnt;
  logic [8:0]  index_nxt;
  logic [2:0]  way_nxt;
  logic [7:0]  word_en_nxt;
  logic [3:0]  quad_en_nxt;

  // Reads are held off while a write strobe is on the array, so the cycle
  // following every write strobe (recovery) never carries a read strobe.
  assign rd_ok      = (state != WR);
  assign asi_elig   = asi_req && !asi_out && (asi_wr ? !tcu_array_wr_inhibit : rd_ok);
  assign fill_elig  = fill_req && !tcu_array_wr_inhibit;
  assign fetch_elig = fetch_req && rd_ok;
  assign starved    = (starve_cnt >= STARVE_LIM);

  assign asi_ack   = asi_elig;
  assign fill_ack  = !asi_elig && fill_elig && (starved || !fetch_elig);
  assign fetch_ack = !asi_elig && fetch_elig && !(fill_elig && starved);

  assign wr_gnt  = fill_ack || (asi_ack && asi_wr);
  assign any_gnt = fill_ack || asi_ack || fetch_ack;
  assign way_gnt = fill_ack || asi_ack;

  always_comb begin
    index_nxt   = fetch_index;
    way_nxt     = fill_way;
    word_en_nxt = 8'h00;
    quad_en_nxt = 4'h0;
    if (asi_ack) begin
      index_nxt   = asi_index;
      way_nxt     = asi_way;
      word_en_nxt = word_onehot(asi_word);
      quad_en_nxt = quad_onehot(asi_word[2:1]);
    end else if (fill_ack) begin
      index_nxt   = fill_index;
      way_nxt     = fill_way;
      word_en_nxt = 8'hFF;
      quad_en_nxt = 4'hF;
    end else if (fetch_ack) begin
      index_nxt   = fetch_index;
      word_en_nxt = fetch_word_en;
      quad_en_nxt = fetch_quad_en;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = wr_gnt ? WR : IDLE;
      WR:      state_nxt = wr_gnt ? WR : WR_RCV;
      WR_RCV:  state_nxt = wr_gnt ? WR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- bf stage: registered array controls ----
  always_ff @(posedge l2clk or posedge arst) begin
    if (arst) begin
      state               <= IDLE;
      starve_cnt          <= 4'd0;
      ic_rd_req_bf        <= 1'b0;
      ic_wr_req_bf        <= 1'b0;
      asi_mbist_access_bf <= 1'b0;
      index_bf            <= 9'd0;
      wrway_bf            <= 3'd0;
      word_en_bf          <= 8'h00;
      quad_en_bf          <= 4'h0;
    end else begin
      state               <= state_nxt;
      ic_rd_req_bf        <= fetch_ack || (asi_ack && !asi_wr);
      ic_wr_req_bf        <= wr_gnt;
      asi_mbist_access_bf <= asi_ack;
      word_en_bf          <= word_en_nxt;
      quad_en_bf          <= quad_en_nxt;
      if (any_gnt) index_bf <= index_nxt;
      if (way_gnt) wrway_bf <= way_nxt;
      if (fill_ack)
        starve_cnt <= 4'd0;
      else if (fill_req && fetch_ack && (starve_cnt < STARVE_LIM))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // ---- ASI read return: track the strobe down to the capture edge ----
  assign asi_rd_bf = asi_mbist_access_bf && ic_rd_req_bf;
  assign rd_chain  = {rd_sr, asi_rd_bf};
  assign asi_rd_vld = rd_sr[RD_LAT-1];

  always_ff @(posedge l2clk or posedge arst) begin
    if (arst) begin
      rd_sr       <= '0;
      asi_out     <= 1'b0;
      asi_rd_data <= 33'd0;
    end else begin
      rd_sr <= rd_chain[RD_LAT-1:0];
      if (rd_chain[RD_LAT-1]) asi_rd_data <= icd_rd_data;
      // A new ASI read cannot be granted while one is outstanding, so set
      // and clear never coincide.
      if (asi_ack && !asi_wr)
        asi_out <= 1'b1;
      else if (rd_chain[RD_LAT-1])
        asi_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_n2_icd_access_ctl.sv
module tb_n2_icd_access_ctl;

  logic        l2clk = 1'b0;
  logic        arst;
  logic        fetch_req;
  logic [8:0]  fetch_index;
  logic [7:0]  fetch_word_en;
  logic [3:0]  fetch_quad_en;
  logic        fetch_ack;
  logic        fill_req;
  logic [8:0]  fill_index;
  logic [2:0]  fill_way;
  logic        fill_ack;
  logic        asi_req;
  logic        asi_wr;
  logic [8:0]  asi_index;
  logic [2:0]  asi_way;
  logic [2:0]  asi_word;
  logic        asi_ack;
  logic [32:0] icd_rd_data;
  logic        tcu_array_wr_inhibit;
  logic [32:0] asi_rd_data;
  logic        asi_rd_vld;
  logic        ic_rd_req_bf;
  logic        ic_wr_req_bf;
  logic        asi_mbist_access_bf;
  logic [8:0]  index_bf;
  logic [2:0]  wrway_bf;
  logic [7:0]  word_en_bf;
  logic [3:0]  quad_en_bf;

  int n_chk  = 0;
  int n_pass = 0;

  n2_icd_access_ctl #(.STARVE_MAX(4), .RD_LAT(2)) dut (
    .l2clk(l2clk), .arst(arst),
    .fetch_req(fetch_req), .fetch_index(fetch_index),
    .fetch_word_en(fetch_word_en), .fetch_quad_en(fetch_quad_en),
    .fetch_ack(fetch_ack),
    .fill_req(fill_req), .fill_index(fill_index), .fill_way(fill_way),
    .fill_ack(fill_ack),
    .asi_req(asi_req), .asi_wr(asi_wr), .asi_index(asi_index),
    .asi_way(asi_way), .asi_word(asi_word), .asi_ack(asi_ack),
    .icd_rd_data(icd_rd_data), .tcu_array_wr_inhibit(tcu_array_wr_inhibit),
    .asi_rd_data(asi_rd_data), .asi_rd_vld(asi_rd_vld),
    .ic_rd_req_bf(ic_rd_req_bf), .ic_wr_req_bf(ic_wr_req_bf),
    .asi_mbist_access_bf(asi_mbist_access_bf), .index_bf(index_bf),
    .wrway_bf(wrway_bf), .word_en_bf(word_en_bf), .quad_en_bf(quad_en_bf)
  );

  always #5 l2clk = ~l2clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge l2clk);
    #1;
  endtask

  initial begin
    arst = 1'b1;
    fetch_req = 0; fetch_index = 0; fetch_word_en = 0; fetch_quad_en = 0;
    fill_req = 0; fill_index = 0; fill_way = 0;
    asi_req = 0; asi_wr = 0; asi_index = 0; asi_way = 0; asi_word = 0;
    icd_rd_data = 33'h0_DEAD_BEEF; tcu_array_wr_inhibit = 0;
    tick(); tick();
    chk("rst_rd",    ic_rd_req_bf, 0);
    chk("rst_wr",    ic_wr_req_bf, 0);
    chk("rst_vld",   asi_rd_vld, 0);
    chk("rst_data",  asi_rd_data, 0);
    chk("rst_index", index_bf, 0);
    arst = 1'b0;
    tick();
    chk("idle_rd", ic_rd_req_bf, 0);
    chk("idle_we", word_en_bf, 0);

    // single fetch read
    fetch_req = 1; fetch_index = 9'h1A3; fetch_word_en = 8'h0F; fetch_quad_en = 4'h3;
    #1;
    chk("f1_ack", fetch_ack, 1);
    chk("f1_fill_ack", fill_ack, 0);
    tick();
    fetch_req = 0;
    chk("f1_rd_bf", ic_rd_req_bf, 1);
    chk("f1_index", index_bf, 9'h1A3);
    chk("f1_we", word_en_bf, 8'h0F);
    chk("f1_qe", quad_en_bf, 4'h3);
    chk("f1_wr_bf", ic_wr_req_bf, 0);
    chk("f1_asi_bf", asi_mbist_access_bf, 0);
    tick();
    chk("f1_rd_off", ic_rd_req_bf, 0);
    chk("f1_we_off", word_en_bf, 0);
    chk("f1_idx_hold", index_bf, 9'h1A3);

    // starvation: four fetches, then the fill is forced
    fetch_req = 1; fetch_index = 9'h055; fetch_word_en = 8'h33; fetch_quad_en = 4'h5;
    fill_req = 1; fill_index = 9'h0AA; fill_way = 3'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("stv_fetch%0d", i), fetch_ack, 1);
      chk($sformatf("stv_nofill%0d", i), fill_ack, 0);
      tick();
    end
    #1;
    chk("stv_fill_ack", fill_ack, 1);
    chk("stv_fetch_ack", fetch_ack, 0);
    tick();
    fill_req = 0;
    chk("stv_wr_bf", ic_wr_req_bf, 1);
    chk("stv_rd_bf", ic_rd_req_bf, 0);
    chk("stv_we", word_en_bf, 8'hFF);
    chk("stv_qe", quad_en_bf, 4'hF);
    chk("stv_way", wrway_bf, 3);
    chk("stv_index", index_bf, 9'h0AA);
    #1;
    chk("stv_blk_fetch", fetch_ack, 0);
    tick();
    chk("rcv_rd_bf", ic_rd_req_bf, 0);
    chk("rcv_wr_bf", ic_wr_req_bf, 0);
    #1;
    chk("rcv_fetch_ack", fetch_ack, 1);
    tick();
    fetch_req = 0;
    chk("rcv_rd_after", ic_rd_req_bf, 1);
    chk("rcv_idx_after", index_bf, 9'h055);
    tick();

    // ASI read, second ASI read waits for the first to return
    asi_req = 1; asi_wr = 0; asi_index = 9'h123; asi_way = 3'd5; asi_word = 3'd6;
    #1;
    chk("ar_ack", asi_ack, 1);
    tick();
    asi_index = 9'h010; asi_way = 3'd2; asi_word = 3'd1;
    icd_rd_data = 33'h1_2345_6789;
    chk("ar_asi_bf", asi_mbist_access_bf, 1);
    chk("ar_rd_bf", ic_rd_req_bf, 1);
    chk("ar_we", word_en_bf, 8'h40);
    chk("ar_qe", quad_en_bf, 4'h8);
    chk("ar_way", wrway_bf, 5);
    chk("ar_index", index_bf, 9'h123);
    chk("ar_2nd_wait0", asi_ack, 0);
    fetch_req = 1; fetch_index = 9'h077; fetch_word_en = 8'h03; fetch_quad_en = 4'h1;
    #1;
    chk("ar_fetch_ok", fetch_ack, 1);
    tick();
    fetch_req = 0;
    #1;
    chk("ar_vld_early", asi_rd_vld, 0);
    chk("ar_2nd_wait1", asi_ack, 0);
    chk("ar_fetch_bf", ic_rd_req_bf & ~asi_mbist_access_bf, 1);
    tick();
    chk("ar_vld", asi_rd_vld, 1);
    chk("ar_data", asi_rd_data, 33'h1_2345_6789);
    chk("ar_2nd_ack", asi_ack, 1);
    tick();
    asi_req = 0;
    icd_rd_data = 33'h1_FEDC_BA98;
    chk("ar_vld_pulse", asi_rd_vld, 0);
    chk("ar2_we", word_en_bf, 8'h02);
    chk("ar2_qe", quad_en_bf, 4'h1);
    tick(); tick();
    chk("ar2_vld", asi_rd_vld, 1);
    chk("ar2_data", asi_rd_data, 33'h1_FEDC_BA98);
    tick();
    chk("ar2_vld_off", asi_rd_vld, 0);
    chk("ar2_data_hold", asi_rd_data, 33'h1_FEDC_BA98);

    // write inhibit holds off ASI write and fill
    tcu_array_wr_inhibit = 1;
    fill_req = 1; fill_index = 9'h0F0; fill_way = 3'd6;
    asi_req = 1; asi_wr = 1; asi_index = 9'h0E0; asi_way = 3'd1; asi_word = 3'd0;
    #1;
    chk("inh_fill_ack", fill_ack, 0);
    chk("inh_asi_ack", asi_ack, 0);
    tick();
    chk("inh_wr_bf", ic_wr_req_bf, 0);
    chk("inh_asi_ack2", asi_ack, 0);
    tcu_array_wr_inhibit = 0;
    #1;
    chk("uninh_asi_ack", asi_ack, 1);
    chk("uninh_fill_ack0", fill_ack, 0);
    tick();
    asi_req = 0; asi_wr = 0;
    chk("uninh_asi_wr_bf", ic_wr_req_bf, 1);
    chk("uninh_asi_bf", asi_mbist_access_bf, 1);
    chk("uninh_asi_way", wrway_bf, 1);
    chk("uninh_asi_we", word_en_bf, 8'h01);
    #1;
    chk("uninh_fill_ack", fill_ack, 1);
    tick();
    fill_req = 0;
    chk("uninh_fill_wr", ic_wr_req_bf, 1);
    chk("uninh_fill_way", wrway_bf, 6);
    chk("uninh_fill_asi", asi_mbist_access_bf, 0);
    tick(); tick();

    // back-to-back fills with fetch pending
    fetch_req = 1; fetch_index = 9'h1C0; fetch_word_en = 8'hF0; fetch_quad_en = 4'hC;
    fill_req = 1; fill_index = 9'h101; fill_way = 3'd2;
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("b2b_fill1", fill_ack, 1);
    tick();
    fill_way = 3'd4;
    chk("b2b_wr1", ic_wr_req_bf, 1);
    chk("b2b_way1", wrway_bf, 2);
    #1;
    chk("b2b_fill2", fill_ack, 1);
    chk("b2b_nofetch1", fetch_ack, 0);
    tick();
    fill_req = 0;
    chk("b2b_wr2", ic_wr_req_bf, 1);
    chk("b2b_way2", wrway_bf, 4);
    #1;
    chk("b2b_nofetch2", fetch_ack, 0);
    tick();
    chk("b2b_bubble_rd", ic_rd_req_bf, 0);
    chk("b2b_bubble_wr", ic_wr_req_bf, 0);
    chk("b2b_fetch_ack", fetch_ack, 1);
    tick();
    fetch_req = 0;
    chk("b2b_rd", ic_rd_req_bf, 1);
    chk("b2b_idx", index_bf, 9'h1C0);
    tick();

    // reset during an in-flight ASI read
    asi_req = 1; asi_wr = 0; asi_index = 9'h1FF; asi_way = 3'd0; asi_word = 3'd3;
    #1;
    chk("rst_asi_ack", asi_ack, 1);
    tick();
    asi_req = 0;
    icd_rd_data = 33'h1_1111_1111;
    chk("rst_asi_rd_bf", ic_rd_req_bf, 1);
    tick();
    arst = 1;
    #1;
    chk("arst_rd_bf", ic_rd_req_bf, 0);
    chk("arst_asi_bf", asi_mbist_access_bf, 0);
    chk("arst_index", index_bf, 0);
    chk("arst_we", word_en_bf, 0);
    chk("arst_data", asi_rd_data, 0);
    tick();
    arst = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arst_novld%0d", i), asi_rd_vld, 0);
      tick();
    end
    chk("arst_data_after", asi_rd_data, 0);
    asi_req = 1;
    #1;
    chk("arst_asi_free", asi_ack, 1);
    asi_req = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
